// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision field layout, constants and the
// stage-to-stage carriers used by the pipelined adder.
package fp32_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'd255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_HI   = 30;
  localparam int unsigned EXP_LO   = 23;
  localparam int unsigned MANT_HI  = 22;
  localparam int unsigned MANT_LO  = 0;

  localparam int unsigned FLAG_INVALID   = 2;
  localparam int unsigned FLAG_OVERFLOW  = 1;
  localparam int unsigned FLAG_UNDERFLOW = 0;

  typedef logic [2:0] fp_flags_t;

  // Unpacked/aligned operands; special results bypass the arithmetic path.
  typedef struct packed {
    logic        special;
    logic [31:0] special_val;
    fp_flags_t   special_flags;
    logic        sign;
    logic        eff_sub;
    logic [7:0]  exp;
    logic [26:0] sig_x;
    logic [26:0] sig_y;
  } align_t;

  typedef struct packed {
    logic        special;
    logic [31:0] special_val;
    fp_flags_t   special_flags;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] sum;
  } addsub_t;

endpackage

// File: rtl/fp_lzc28.sv
// Combinational leading-zero counter for the 28-bit raw sum; an all-zero
// input reports 28.
module fp_lzc28 (
  input  logic [27:0] value,
  output logic [4:0]  count
);

  logic found;

  always_comb begin
    count = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 28; i++) begin
      if (!found) begin
        if (value[27 - i]) found = 1'b1;
        else               count = count + 5'd1;
      end
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage pipelined single-precision adder/subtractor with
// valid/ready handshake, round-toward-zero and flushed subnormals.
module fp_add_pipe
  import fp32_pkg::*;
#(
  parameter int unsigned TAG_W        = 5,
  parameter int unsigned FLUSH_DENORM = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_flags
);

  localparam bit FLUSH = (FLUSH_DENORM != 0);

  logic adv;
  logic out_valid_q;

  // Masking with reset keeps the reset cycle itself free of output transfers.
  assign out_valid = out_valid_q & ~reset;
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;

  // ---------------- stage 1: unpack / align ----------------
  logic [31:0]      b_eff;
  logic [7:0]       ea, eb, x_exp, y_exp, shift_d;
  logic [22:0]      x_mant, y_mant;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [26:0]      y_field, y_shifted, lost_mask;
  align_t           s1_d, s1_q;
  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;

  always_comb begin
    b_eff  = {in_b[SIGN_BIT] ^ in_sub, in_b[EXP_HI:MANT_LO]};
    ea     = in_a[EXP_HI:EXP_LO];
    eb     = b_eff[EXP_HI:EXP_LO];
    a_zero = (ea == '0) && (FLUSH || (in_a[MANT_HI:MANT_LO] == '0));
    b_zero = (eb == '0) && (FLUSH || (b_eff[MANT_HI:MANT_LO] == '0));
    a_inf  = (ea == EXP_MAX) && (in_a[MANT_HI:MANT_LO] == '0);
    b_inf  = (eb == EXP_MAX) && (b_eff[MANT_HI:MANT_LO] == '0);
    a_nan  = (ea == EXP_MAX) && (in_a[MANT_HI:MANT_LO] != '0);
    b_nan  = (eb == EXP_MAX) && (b_eff[MANT_HI:MANT_LO] != '0);

    swap      = b_eff[EXP_HI:MANT_LO] > in_a[EXP_HI:MANT_LO];
    x_exp     = swap ? eb : ea;
    y_exp     = swap ? ea : eb;
    x_mant    = swap ? b_eff[MANT_HI:MANT_LO] : in_a[MANT_HI:MANT_LO];
    y_mant    = swap ? in_a[MANT_HI:MANT_LO] : b_eff[MANT_HI:MANT_LO];
    shift_d   = x_exp - y_exp;
    y_field   = {1'b1, y_mant, 3'b000};
    y_shifted = y_field >> shift_d;
    lost_mask = (27'd1 << shift_d) - 27'd1;

    s1_d         = '0;
    s1_d.sign    = swap ? b_eff[SIGN_BIT] : in_a[SIGN_BIT];
    s1_d.eff_sub = in_a[SIGN_BIT] ^ b_eff[SIGN_BIT];
    s1_d.exp     = x_exp;
    s1_d.sig_x   = {1'b1, x_mant, 3'b000};
    if (shift_d >= 8'd27)
      s1_d.sig_y = 27'd1;
    else
      s1_d.sig_y = {y_shifted[26:1], y_shifted[0] | (|(y_field & lost_mask))};

    s1_d.special = 1'b1;
    if (a_nan || b_nan || (a_inf && b_inf && s1_d.eff_sub)) begin
      s1_d.special_val                 = QNAN;
      s1_d.special_flags[FLAG_INVALID] = 1'b1;
    end else if (a_inf) begin
      s1_d.special_val = in_a;
    end else if (b_inf) begin
      s1_d.special_val = b_eff;
    end else if (a_zero && b_zero) begin
      s1_d.special_val = {in_a[SIGN_BIT] & b_eff[SIGN_BIT], 31'b0};
    end else if (a_zero) begin
      s1_d.special_val = b_eff;
    end else if (b_zero) begin
      s1_d.special_val = in_a;
    end else begin
      s1_d.special = 1'b0;
    end
  end

  // ---------------- stage 2: add / subtract ----------------
  addsub_t          s2_d, s2_q;
  logic             s2_valid;
  logic [TAG_W-1:0] s2_tag;

  always_comb begin
    s2_d               = '0;
    s2_d.special       = s1_q.special;
    s2_d.special_val   = s1_q.special_val;
    s2_d.special_flags = s1_q.special_flags;
    s2_d.sign          = s1_q.sign;
    s2_d.exp           = s1_q.exp;
    if (s1_q.eff_sub)
      s2_d.sum = {1'b0, s1_q.sig_x} - {1'b0, s1_q.sig_y};
    else
      s2_d.sum = {1'b0, s1_q.sig_x} + {1'b0, s1_q.sig_y};
  end

  // ---------------- stage 3: normalize / pack ----------------
  logic [4:0]         lzc, norm_shift;
  logic [26:0]        norm;
  logic signed [9:0]  exp_n;
  logic [31:0]        res_sum;
  fp_flags_t          res_flags;
  logic               norm_unused;

  fp_lzc28 u_lzc (
    .value (s2_q.sum),
    .count (lzc)
  );

  always_comb begin
    norm_shift = lzc - 5'd1;
    if (s2_q.sum[27]) begin
      norm  = {s2_q.sum[27:2], s2_q.sum[1] | s2_q.sum[0]};
      exp_n = $signed({2'b00, s2_q.exp}) + 10'sd1;
    end else begin
      // Bit 27 is clear here, so lzc >= 1; shift the leading one to bit 26.
      norm  = s2_q.sum[26:0] << norm_shift;
      exp_n = $signed({2'b00, s2_q.exp}) - $signed({5'b00000, norm_shift});
    end

    res_flags = '0;
    if (s2_q.special) begin
      res_sum   = s2_q.special_val;
      res_flags = s2_q.special_flags;
    end else if (s2_q.sum == '0) begin
      res_sum = '0;
    end else if (exp_n >= 10'sd255) begin
      res_sum                  = {s2_q.sign, EXP_MAX, 23'b0};
      res_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (exp_n <= 10'sd0) begin
      res_sum                   = {s2_q.sign, 31'b0};
      res_flags[FLAG_UNDERFLOW] = 1'b1;
    end else begin
      res_sum = {s2_q.sign, exp_n[7:0], norm[25:3]};
    end
  end

  // Hidden bit and guard/round/sticky are dropped by truncation.
  assign norm_unused = ^{norm[26], norm[2:0]};

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_q        <= '0;
      s1_tag      <= '0;
      s2_valid    <= 1'b0;
      s2_q        <= '0;
      s2_tag      <= '0;
      out_valid_q <= 1'b0;
      out_sum     <= '0;
      out_tag     <= '0;
      out_flags   <= '0;
    end else if (adv) begin
      s1_valid    <= in_valid;
      s1_q        <= s1_d;
      s1_tag      <= in_tag;
      s2_valid    <= s1_valid;
      s2_q        <= s2_d;
      s2_tag      <= s1_tag;
      out_valid_q <= s2_valid;
      out_sum     <= res_sum;
      out_tag     <= s2_tag;
      out_flags   <= res_flags;
    end
  end

endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
Three-stage pipelined IEEE-754 single-precision adder/subtractor.
Sits directly downstream of the 32x32 register-file memory and consumes its read-data words as operands.
Each operand pair is tagged with a 5-bit destination address; the result and its address go to the register-file write port or to the compare/check logic.
Replaces the purely combinational adder so the operand path is registered and supports backpressure.

Parameters:
TAG_W, 5, width of destination-address tag carried alongside the operands
FLUSH_DENORM, 1, 1 = subnormal inputs are treated as signed zero (the only supported value)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high; clears all stage valids
in_valid  in  1  operand pair present
in_ready  out  1  stage 1 can accept a pair this cycle
in_a  in  32  operand A, IEEE-754 single
in_b  in  32  operand B, IEEE-754 single
in_sub  in  1  1 = compute A-B (invert sign of B)
in_tag  in  TAG_W  destination address, passed through unchanged
out_valid  out  1  result present
out_ready  in  1  consumer accepts the result this cycle
out_sum  out  32  IEEE-754 result
out_tag  out  TAG_W  tag matching out_sum
out_flags  out  3  {invalid, overflow, underflow}

Behaviour:
- Reset: every stage valid = 0; out_valid = 0, out_sum = 0, out_tag = 0, out_flags = 0. Data registers are also cleared.
- Advance: adv = out_ready | ~out_valid. All stages shift together when adv = 1 and hold otherwise. in_ready = adv.
- Transfer rules: input transfers when in_valid & in_ready; output transfers when out_valid & out_ready.
- Latency: exactly 3 cycles from input transfer to out_valid when there is no stall. Throughput is 1 result per cycle.
- Pipeline bubbles propagate as valid = 0. Data in invalid stages is don't-care, but out_sum must be stable while out_valid & ~out_ready.
- Stage 1 (unpack/align):
  - Decode special cases: exp = 255 gives Inf/NaN; exp = 0 gives zero (subnormals flushed, sign kept).
  - Form 24-bit significands with the hidden bit.
  - Swap the operands so that the larger magnitude is X, comparing {exp, mant}.
  - Right-shift Y's significand by d = eX - eY into a 27-bit field (24 + guard + round + sticky). Sticky is the OR of all bits shifted out.
  - If d >= 27, Y reduces to sticky only (sticky = 1 if Y is nonzero).
- Stage 2 (add/sub):
  - Effective subtract = sA ^ sB'. Produce a 28-bit sum or difference.
  - Result sign = sign of X.
- Stage 3 (normalize/pack):
  - On carry-out: shift right 1, OR the lost bit into sticky, exponent + 1.
  - Otherwise: left-shift by the leading-zero count (0..26), subtracting from the exponent.
  - Rounding is round-toward-zero: truncate the guard, round and sticky bits.
- Exact zero result = +0, except (-0)+(-0) = -0.
- Overflow: exponent >= 255 gives ±Inf, overflow flag = 1.
- Underflow: normalized exponent <= 0 gives ±0, underflow flag = 1.
- Specials take precedence over arithmetic:
  - Any NaN input, or Inf - Inf (effective subtract): output 0x7FC00000, invalid = 1.
  - Inf op finite: output the Inf with its sign.
  - Zero op X: output X, exact with no rounding.
- Reset asserted mid-operation drops all in-flight results; no output transfer occurs in the reset cycle or the cycle after.
- Simultaneous input and output transfer in the same cycle is legal and required for full throughput.

Decomposition:
- Shared package fp32_pkg:
  - constants EXP_BIAS = 127, EXP_MAX = 255, QNAN = 32'h7FC00000
  - field-slice localparams (sign bit 31, exp [30:23], mant [22:0])
  - flag bit indices
- One sub-module: fp_lzc28, a combinational 28-bit leading-zero counter with a 5-bit count, used in stage 3.

Test Plan:
- 0x3F800000 + 0x40000000, tag 0x16, out_ready = 1 -> after 3 cycles out_sum = 0x40400000, tag 0x16, flags 0.
- 0x41800000 - 0x3F800000 (in_sub = 1) -> 0x41700000; 0x3FC00000 + 0xBFC00000 -> 0x00000000; 0x80000000 + 0x80000000 -> 0x80000000.
- Rounding/sticky: 0x3F800000 + 0xB0800000 -> 0x3F7FFFFF; 0x3F800000 + 0x33800000 -> 0x3F800000; 0x00000001 + 0x3F800000 -> 0x3F800000.
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow = 1
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid = 1
  - 0xFF800000 + 0x3F800000 -> 0xFF800000
- Backpressure: stream 5 back-to-back pairs with out_ready low for cycles 4-6 -> in_ready low those cycles, out_sum held stable, all 5 results emitted in order with no loss or duplication.
- Reset mid-stream: assert reset with 3 pairs in flight -> out_valid = 0 the following cycle, in_ready = 1. Then one new pair produces its result 3 cycles after the input transfer.
